// File: rtl/edge_arb_pkg.sv
// Shared types and defaults for the edge-event arbiter.
package edge_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OFFER = 2'd1,
        ARB_BUSY  = 2'd2
    } arb_state_t;

    localparam int DROP_W_DEFAULT = 8;

endpackage

// File: rtl/edge_pending_cell.sv
// One requester: rising-edge detect on the level input and a sticky pending flag.
module edge_pending_cell (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic clr,
    output logic pending,
    output logic drop
);

    logic prev_q;
    logic rise;

    assign rise = req & ~prev_q;
    // A new edge while still pending is lost, unless the old event is being taken this cycle.
    assign drop = rise & pending & ~clr;

    // prev_q tracks the line even in reset so a level held through reset is not an event.
    always_ff @(posedge clk) begin
        prev_q <= req;
        if (!rst) pending <= 1'b0;
        else      pending <= rise | (pending & ~clr);
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Round-robin arbiter handing pending edge events to a single downstream resource,
// one offer/accept/done job at a time.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int DROP_W = DROP_W_DEFAULT,
    localparam int IDW    = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req_in,
    output logic              grant_valid,
    output logic [IDW-1:0]    grant_id,
    input  logic              grant_ready,
    input  logic              done,
    output logic [N_REQ-1:0]  pending,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int          SUM_W    = DROP_W + 5;
    localparam logic [IDW:0] N_W     = (IDW+1)'(N_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

    arb_state_t       state, state_d;
    logic [IDW-1:0]   ptr, ptr_d;
    logic [IDW-1:0]   grant_id_d;
    logic             grant_valid_d, busy_d;
    logic [N_REQ-1:0] clr, drop;
    logic [IDW-1:0]   sel;
    logic             found;
    logic [IDW:0]     cand;
    logic [4:0]       drop_n;
    logic [SUM_W-1:0] drop_sum;

    for (genvar i = 0; i < N_REQ; i++) begin : g_cell
        assign clr[i] = grant_valid & grant_ready & (grant_id == IDW'(i));
        edge_pending_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .req     (req_in[i]),
            .clr     (clr[i]),
            .pending (pending[i]),
            .drop    (drop[i])
        );
    end

    // First pending index at or after ptr, wrapping at N_REQ (not a power of two in general).
    always_comb begin
        sel   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= N_W) cand = cand - N_W;
            if (!found && pending[cand[IDW-1:0]]) begin
                found = 1'b1;
                sel   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        drop_n = '0;
        for (int i = 0; i < N_REQ; i++) drop_n = drop_n + 5'(drop[i]);
        drop_sum = SUM_W'(drop_cnt) + SUM_W'(drop_n);
    end

    always_comb begin
        state_d       = state;
        grant_valid_d = grant_valid;
        grant_id_d    = grant_id;
        busy_d        = busy;
        ptr_d         = ptr;
        case (state)
            ARB_IDLE: begin
                if (found) begin
                    grant_id_d    = sel;
                    grant_valid_d = 1'b1;
                    state_d       = ARB_OFFER;
                end
            end
            ARB_OFFER: begin
                if (grant_ready) begin
                    grant_valid_d = 1'b0;
                    busy_d        = 1'b1;
                    state_d       = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (done) begin
                    busy_d  = 1'b0;
                    ptr_d   = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ARB_IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            busy        <= 1'b0;
            ptr         <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_d;
            grant_valid <= grant_valid_d;
            grant_id    <= grant_id_d;
            busy        <= busy_d;
            ptr         <= ptr_d;
            drop_cnt    <= (drop_sum > SUM_W'({DROP_W{1'b1}})) ? {DROP_W{1'b1}}
                                                               : drop_sum[DROP_W-1:0];
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: vector table, directed corner sequences and random traffic
// against an event-level reference model.
module tb_edge_event_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int IDW = 2;
    localparam int SAT = (1 << DW) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_in = '0;
    logic           grant_ready = 1'b0;
    logic           done = 1'b0;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic [N-1:0]   pending;
    logic           busy;
    logic [DW-1:0]  drop_cnt;

    int errors = 0;
    int checks = 0;

    edge_event_arbiter #(.N_REQ(N), .DROP_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_in      (req_in),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .grant_ready (grant_ready),
        .done        (done),
        .pending     (pending),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 offering, 2 job running.
    bit [N-1:0] m_prev, m_pend;
    bit         m_gv, m_busy;
    int         m_ptr, m_phase, m_gid, m_drop;

    task automatic model_step();
        bit [N-1:0] np;
        bit         hs, rise, taken;
        int         drops;
        if (!rst) begin
            m_prev = req_in; m_pend = '0; m_ptr = 0; m_phase = 0;
            m_gv = 0; m_gid = 0; m_busy = 0; m_drop = 0;
            return;
        end
        hs = m_gv && grant_ready;
        drops = 0;
        for (int i = 0; i < N; i++) begin
            rise  = req_in[i] && !m_prev[i];
            taken = hs && (m_gid == i);
            if (rise && m_pend[i] && !taken) drops++;
            np[i] = rise || (m_pend[i] && !taken);
        end
        m_drop = (m_drop + drops > SAT) ? SAT : m_drop + drops;
        case (m_phase)
            0: if (m_pend != 0) begin
                for (int k = 0; k < N; k++)
                    if (m_pend[(m_ptr + k) % N]) begin m_gid = (m_ptr + k) % N; break; end
                m_gv = 1; m_phase = 1;
            end
            1: if (grant_ready) begin m_gv = 0; m_busy = 1; m_phase = 2; end
            default: if (done) begin m_busy = 0; m_ptr = (m_gid + 1) % N; m_phase = 0; end
        endcase
        m_pend = np;
        m_prev = req_in;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [63:0] pack_dut();
        return 64'({grant_valid, 8'(grant_id), 16'(pending), busy, 8'(drop_cnt)});
    endfunction

    function automatic logic [63:0] pack_model();
        return 64'({m_gv, 8'(m_gid), 16'(m_pend), m_busy, 8'(m_drop)});
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmp_model(string name);
        chk(name, pack_dut(), pack_model());
    endtask

    typedef struct {
        logic [N-1:0]   req;
        logic           rdy;
        logic           dn;
        logic           gv;
        logic [IDW-1:0] gid;
        logic [N-1:0]   pend;
        logic           bsy;
    } vec_t;

    vec_t tbl[14];
    int   order[$];
    int   exp_order[4];
    int   bcnt;

    initial begin
        // Rise on 2 and its grant, then a rise on 3 during its own accept cycle.
        tbl[0]  = '{4'b0110, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0};
        tbl[1]  = '{4'b0110, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0};
        tbl[2]  = '{4'b0110, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1};
        tbl[3]  = '{4'b0110, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0};
        tbl[4]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0};
        tbl[5]  = '{4'b1010, 1'b0, 1'b0, 1'b0, 2'd2, 4'b1000, 1'b0};
        tbl[6]  = '{4'b1010, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0};
        tbl[7]  = '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0};
        tbl[8]  = '{4'b1010, 1'b1, 1'b0, 1'b0, 2'd3, 4'b1000, 1'b1};
        tbl[9]  = '{4'b1010, 1'b0, 1'b0, 1'b0, 2'd3, 4'b1000, 1'b1};
        tbl[10] = '{4'b1010, 1'b0, 1'b1, 1'b0, 2'd3, 4'b1000, 1'b0};
        tbl[11] = '{4'b1010, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0};
        tbl[12] = '{4'b1010, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b1};
        tbl[13] = '{4'b1010, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0};
        exp_order = '{0, 1, 3, 0};

        // Reset with a line held high: no event after release.
        req_in = 4'b0010;
        rst = 1'b0;
        cyc(); cyc();
        chk("reset_state", pack_dut(), 64'd0);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            chk("held_line_no_event", 64'({grant_valid, pending, busy}), 64'd0);
        end

        for (int i = 0; i < 14; i++) begin
            req_in = tbl[i].req; grant_ready = tbl[i].rdy; done = tbl[i].dn;
            cyc();
            chk($sformatf("vec%0d", i),
                64'({grant_valid, grant_id, pending, busy, drop_cnt}),
                64'({tbl[i].gv, tbl[i].gid, tbl[i].pend, tbl[i].bsy, 8'd0}));
        end
        done = 1'b0;

        // Simultaneous rises on 0,1,3, jobs done 2 cycles after accept; then a fresh rise on 0.
        req_in = 4'b0000; cyc(); cmp_model("rr_prep");
        req_in = 4'b1011;
        bcnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 25) req_in = 4'b1010;
            if (c == 26) req_in = 4'b1011;
            grant_ready = 1'b1;
            done = busy && (bcnt == 2);
            cyc();
            cmp_model("rr_cycle");
            bcnt = busy ? bcnt + 1 : 0;
            if (grant_valid) order.push_back(int'(grant_id));
        end
        done = 1'b0;
        chk("rr_count", 64'(order.size()), 64'd4);
        for (int k = 0; k < 4 && k < order.size(); k++)
            chk($sformatf("rr_order%0d", k), 64'(order[k]), 64'(exp_order[k]));

        // Requester 1 re-triggers while its offer is stalled: drops then saturation.
        grant_ready = 1'b0;
        req_in = 4'b1001; cyc(); cmp_model("drop_fall");
        req_in = 4'b1011; cyc(); cmp_model("drop_rise");
        req_in = 4'b1001; cyc();
        req_in = 4'b1011; cyc();
        chk("drop_first", 64'({pending[1], drop_cnt}), 64'({1'b1, 8'd1}));
        for (int c = 0; c < 300; c++) begin
            req_in = 4'b1001; cyc();
            req_in = 4'b1011; cyc(); cmp_model("drop_loop");
        end
        chk("drop_saturate", 64'(drop_cnt), 64'(SAT));

        // Reset in the middle of a job, then a stray done.
        grant_ready = 1'b1; cyc(); cmp_model("accept_before_rst");
        chk("busy_before_rst", 64'(busy), 64'd1);
        grant_ready = 1'b0; cyc();
        rst = 1'b0; cyc();
        rst = 1'b1;
        chk("rst_mid_busy", pack_dut(), 64'd0);
        done = 1'b1; cyc();
        chk("stray_done", pack_dut(), 64'd0);
        done = 1'b0; cyc();
        chk("idle_after_stray", pack_dut(), 64'd0);

        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) req_in[i] = ~req_in[i];
            grant_ready = 1'($urandom_range(0, 1));
            done = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 149) != 0);
            cyc();
            cmp_model("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
